layer_sequencer: RTL and testbench

Controller that owns the weight `memory` and the `layer` datapath. It loads a stream of LAYER_DEPTH×LAYER_SIZE weights into memory in layer-major, node-minor order over a valid/ready handshake. It then steps the `layer` datapath through every stored layer, one layer per LAYER_CYCLES clocks, selecting external input for layer 0 and feedback for the layers after it. It sits between the host/stream interface and the `memory` + `layer` pair.

---
 rtl/layer_sequencer.sv | 147 ++++++++++++++
 tb/tb_layer_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Weight-load / inference sequencer driving the weight memory and layer datapath.
// Optional abort input enabled by defining LAYER_SEQ_ABORT_EN.
module layer_sequencer #(
    parameter int BIT_SIZE     = 16,
    parameter int LAYER_SIZE   = 4,
    parameter int LAYER_DEPTH  = 4,
    parameter int LAYER_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef LAYER_SEQ_ABORT_EN
    input  logic                           abort,
`endif
    input  logic                           load_start,
    input  logic                           run_start,
    input  logic                           w_valid,
    input  logic [BIT_SIZE-1:0]            w_data,
    output logic                           w_ready,
    output logic                           mem_write,
    output logic [$clog2(LAYER_DEPTH)-1:0] mem_layer,
    output logic [$clog2(LAYER_SIZE)-1:0]  mem_node,
    output logic [BIT_SIZE-1:0]            mem_w_in,
    output logic                           input_select,
    output logic                           layer_en,
    output logic                           busy,
    output logic                           load_done,
    output logic                           run_done
);
    localparam int LW = $clog2(LAYER_DEPTH);
    localparam int NW = $clog2(LAYER_SIZE);
    localparam int CW = (LAYER_CYCLES > 1) ? $clog2(LAYER_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t              r_state, w_next;
    logic [LW+NW-1:0]    r_beat;       // {layer,node} load counter, layer-major
    logic [CW-1:0]       r_cyc;
    logic                r_mem_write;
    logic [LW-1:0]       r_mem_layer;
    logic [NW-1:0]       r_mem_node;
    logic [BIT_SIZE-1:0] r_mem_w_in;
    logic                r_load_done;
    logic                r_run_done;

    logic w_abort, w_accept, w_last_beat, w_layer_end, w_last_layer;

`ifdef LAYER_SEQ_ABORT_EN
    assign w_abort = abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept     = (r_state == S_LOAD) && w_valid;
    assign w_last_beat  = w_accept && (&r_beat);
    assign w_layer_end  = (r_state == S_RUN) && (r_cyc == CW'(LAYER_CYCLES - 1));
    assign w_last_layer = w_layer_end && (&r_mem_layer);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                // Load wins a tie; the run request is dropped, not queued.
                if (load_start)     w_next = S_LOAD;
                else if (run_start) w_next = S_RUN;
            end
            S_LOAD:  if (w_last_beat)  w_next = S_IDLE;
            S_RUN:   if (w_last_layer) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat      <= '0;
            r_cyc       <= '0;
            r_mem_write <= 1'b0;
            r_mem_layer <= '0;
            r_mem_node  <= '0;
            r_mem_w_in  <= '0;
            r_load_done <= 1'b0;
            r_run_done  <= 1'b0;
        end else begin
            r_mem_write <= 1'b0;
            r_load_done <= 1'b0;
            r_run_done  <= 1'b0;
            if (w_abort) begin
                r_beat      <= '0;
                r_cyc       <= '0;
                r_mem_layer <= '0;
                r_mem_node  <= '0;
                r_mem_w_in  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_beat <= '0;
                        r_cyc  <= '0;
                        if (w_next == S_RUN) begin
                            r_mem_layer <= '0;
                            r_mem_node  <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (w_accept) begin
                            r_mem_write               <= 1'b1;
                            r_mem_w_in                <= w_data;
                            {r_mem_layer, r_mem_node} <= r_beat;
                            r_beat                    <= r_beat + 1'b1;
                            r_load_done               <= w_last_beat;
                        end
                    end
                    S_RUN: begin
                        if (w_layer_end) begin
                            r_cyc <= '0;
                            if (&r_mem_layer) begin
                                r_mem_layer <= '0;
                                r_run_done  <= 1'b1;
                            end else begin
                                r_mem_layer <= r_mem_layer + 1'b1;
                            end
                        end else begin
                            r_cyc <= r_cyc + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_ready      = (r_state == S_LOAD);
    assign layer_en     = (r_state == S_RUN);
    assign busy         = (r_state != S_IDLE);
    assign input_select = (r_state != S_RUN) || (r_mem_layer == '0);
    assign mem_write    = r_mem_write;
    assign mem_layer    = r_mem_layer;
    assign mem_node     = r_mem_node;
    assign mem_w_in     = r_mem_w_in;
    assign load_done    = r_load_done;
    assign run_done     = r_run_done;
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: write scoreboard fed at stimulus time, popped on mem_write.
// Abort scenarios compile in when LAYER_SEQ_ABORT_EN is defined.
module tb_layer_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_start, run_start, w_valid;
    logic [15:0] w_data;
`ifdef LAYER_SEQ_ABORT_EN
    logic        abort;
`endif
    logic        w_ready, mem_write, input_select, layer_en, busy, load_done, run_done;
    logic [1:0]  mem_layer, mem_node;
    logic [15:0] mem_w_in;

    typedef struct packed {
        logic [1:0]  layer;
        logic [1:0]  node;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0, n_fail = 0;
    int  n_writes = 0, n_exp_writes = 0, n_load_done = 0, n_run_done = 0;

    layer_sequencer #(.BIT_SIZE(16), .LAYER_SIZE(4), .LAYER_DEPTH(4), .LAYER_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
`ifdef LAYER_SEQ_ABORT_EN
        .abort(abort),
`endif
        .load_start(load_start), .run_start(run_start),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .mem_write(mem_write), .mem_layer(mem_layer), .mem_node(mem_node), .mem_w_in(mem_w_in),
        .input_select(input_select), .layer_en(layer_en), .busy(busy),
        .load_done(load_done), .run_done(run_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int idx, input logic [15:0] d);
        exp_q.push_back('{layer: 2'(idx / 4), node: 2'(idx % 4), data: d});
        n_exp_writes++;
    endtask

    // Scoreboard consumer: every write strobe must match the next expected beat.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_write) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", 32'(mem_write), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_layer", 32'(mem_layer), 32'(mon_e.layer));
                    check("wr_node",  32'(mem_node),  32'(mon_e.node));
                    check("wr_data",  32'(mem_w_in),  32'(mon_e.data));
                end
            end
            if (load_done) n_load_done++;
            if (run_done)  n_run_done++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int run_len;
        logic v;

        // Reset with random inputs
        rst        = 1'b1;
        load_start = 1'($urandom);
        run_start  = 1'($urandom);
        w_valid    = 1'($urandom);
        w_data     = 16'($urandom);
`ifdef LAYER_SEQ_ABORT_EN
        abort      = 1'($urandom);
`endif
        tick();
        check("rst_w_ready",      32'(w_ready),      32'd0);
        check("rst_mem_write",    32'(mem_write),    32'd0);
        check("rst_mem_layer",    32'(mem_layer),    32'd0);
        check("rst_mem_node",     32'(mem_node),     32'd0);
        check("rst_mem_w_in",     32'(mem_w_in),     32'd0);
        check("rst_input_select", 32'(input_select), 32'd1);
        check("rst_layer_en",     32'(layer_en),     32'd0);
        check("rst_busy",         32'(busy),         32'd0);
        check("rst_load_done",    32'(load_done),    32'd0);
        check("rst_run_done",     32'(run_done),     32'd0);
        load_start = 1'b0; run_start = 1'b0; w_valid = 1'b0; w_data = '0;
`ifdef LAYER_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        rst = 1'b0;
        tick();

        // Full load, back-to-back beats
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("load_enter_w_ready", 32'(w_ready), 32'd1);
        check("load_enter_busy",    32'(busy),    32'd1);
        for (int i = 0; i < 16; i++) begin
            w_valid = 1'b1;
            w_data  = 16'(i);
            push_exp(i, 16'(i));
            tick();
            check("load1_mem_write", 32'(mem_write), 32'd1);
            check("load1_done",      32'(load_done), 32'(i == 15));
            check("load1_w_ready",   32'(w_ready),   32'(i != 15));
        end
        w_valid = 1'b0;
        check("load1_end_busy",  32'(busy),      32'd0);
        check("load1_end_layer", 32'(mem_layer), 32'd3);
        check("load1_end_node",  32'(mem_node),  32'd3);
        tick();
        check("load1_after_write", 32'(mem_write), 32'd0);
        check("load1_after_done",  32'(load_done), 32'd0);
        check("load1_writes",      32'(n_writes),  32'(n_exp_writes));
        check("load1_done_count",  32'(n_load_done), 32'd1);

        // Stalled load: w_valid toggling 1,0,1,0...
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int s = 0; s < 32; s++) begin
            w_valid = (s % 2 == 0);
            w_data  = w_valid ? 16'(16'hA000 + s / 2) : 16'hDEAD;
            if (w_valid) push_exp(s / 2, w_data);
            tick();
            check("stall_mem_write", 32'(mem_write), 32'(s % 2 == 0));
            check("stall_load_done", 32'(load_done), 32'(s == 30));
            check("stall_busy",      32'(busy),      32'(s < 30));
        end
        w_valid = 1'b0;
        tick();
        check("stall_writes",     32'(n_writes),    32'(n_exp_writes));
        check("stall_done_count", 32'(n_load_done), 32'd2);

        // Run with a redundant run_start mid-run
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            check("run_layer_en",     32'(layer_en),     32'd1);
            check("run_mem_layer",    32'(mem_layer),    32'(c / 4));
            check("run_input_select", 32'(input_select), 32'(c < 4));
            check("run_mem_node",     32'(mem_node),     32'd0);
            check("run_mem_write",    32'(mem_write),    32'd0);
            check("run_done_early",   32'(run_done),     32'd0);
            run_start = (c == 5);
            tick();
        end
        run_start = 1'b0;
        check("run_done_pulse",   32'(run_done),     32'd1);
        check("run_end_busy",     32'(busy),         32'd0);
        check("run_end_layer_en", 32'(layer_en),     32'd0);
        check("run_end_in_sel",   32'(input_select), 32'd1);
        check("run_end_layer",    32'(mem_layer),    32'd0);

        // Both starts in the run_done cycle: load must win
        load_start = 1'b1;
        run_start  = 1'b1;
        tick();
        load_start = 1'b0;
        run_start  = 1'b0;
        check("tie_w_ready",  32'(w_ready),  32'd1);
        check("tie_layer_en", 32'(layer_en), 32'd0);
        check("tie_run_done", 32'(run_done), 32'd0);

        // Random-valid load, bounded
        accepted = 0;
        for (int cyc = 0; cyc < 300 && accepted < 16; cyc++) begin
            v       = 1'($urandom_range(0, 1));
            w_valid = v;
            w_data  = 16'($urandom);
            if (v) begin
                push_exp(accepted, w_data);
                accepted++;
            end
            tick();
        end
        w_valid = 1'b0;
        check("rand_load_busy", 32'(busy), 32'd0);
        tick();
        check("rand_load_done_count", 32'(n_load_done), 32'd3);

        // Second run, load_start during RUN must be ignored
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        run_len = 0;
        while (layer_en && run_len < 100) begin
            load_start = (run_len == 3);
            run_len++;
            tick();
        end
        load_start = 1'b0;
        check("run2_length",   32'(run_len),  32'd16);
        check("run2_done",     32'(run_done), 32'd1);
        check("run2_no_load",  32'(w_ready),  32'd0);
        tick();
        check("run_done_count", 32'(n_run_done), 32'd2);

`ifdef LAYER_SEQ_ABORT_EN
        // Abort after 5 beats, then reload from (0,0)
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w_valid = 1'b1;
            w_data  = 16'(16'hB000 + i);
            push_exp(i, w_data);
            tick();
        end
        w_valid = 1'b0;
        abort   = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_w_ready",   32'(w_ready),   32'd0);
        check("abort_load_done", 32'(load_done), 32'd0);
        check("abort_mem_write", 32'(mem_write), 32'd0);
        check("abort_mem_layer", 32'(mem_layer), 32'd0);
        check("abort_mem_w_in",  32'(mem_w_in),  32'd0);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w_valid = 1'b1;
            w_data  = 16'(16'hC000 + i);
            push_exp(i, w_data);
            tick();
        end
        w_valid = 1'b0;
        check("reload_done", 32'(load_done), 32'd1);
        tick();
        check("abort_done_count", 32'(n_load_done), 32'd4);
`endif

        tick();
        check("sb_empty",     32'(exp_q.size()), 32'd0);
        check("total_writes", 32'(n_writes),     32'(n_exp_writes));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
